// File: rtl/uart_tx_serializer_if.sv
// Byte handshake from the UART store path into the TX serializer.
// The producer holds tx_valid/tx_data until tx_ready; a transfer is tx_valid & tx_ready.
interface uart_tx_serializer_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART TX serializer: the start bit appears at the first baud tick after acceptance; every tx edge lands one cycle after a tick.
// tx_ready is high only in IDLE, so one byte is held per frame and the producer waits out the frame.
module uart_tx_serializer #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                    clock_in,
  input  logic                    rst,
  input  logic                    baud_clk,
  uart_tx_serializer_if.slave     bus,
  output logic                    tx,
  output logic                    busy,
  output logic                    tx_done
);

  localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [CW-1:0]        bit_cnt_q;
  logic                 stop_cnt_q;
  logic                 parity_q;
  logic                 baud_clk_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 ready_q;
  logic                 baud_tick_d;

  // baud_clk shares clock_in's domain, so a one-register edge detector is enough.
  assign baud_tick_d = baud_clk & ~baud_clk_q;

  always_ff @(posedge clock_in or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      baud_clk_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      baud_clk_q <= baud_clk;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (bus.tx_valid && ready_q) begin
            shift_q  <= bus.tx_data;
            parity_q <= (^bus.tx_data) ^ 1'(PARITY_ODD);
            state_q  <= S_SYNC;
            busy_q   <= 1'b1;
            ready_q  <= 1'b0;
          end
        end
        S_SYNC: begin
          if (baud_tick_d) begin
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (baud_tick_d) begin
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= '0;
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_tick_d) begin
            if (bit_cnt_q == CW'(DATA_BITS - 1)) begin
              stop_cnt_q <= 1'b0;
              if (PARITY_EN != 0) begin
                tx_q    <= parity_q;
                state_q <= S_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= S_STOP;
              end
            end else begin
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q + CW'(1);
            end
          end
        end
        S_PARITY: begin
          if (baud_tick_d) begin
            tx_q       <= 1'b1;
            stop_cnt_q <= 1'b0;
            state_q    <= S_STOP;
          end
        end
        S_STOP: begin
          if (baud_tick_d) begin
            if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              stop_cnt_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.tx_ready = ready_q;
  assign tx           = tx_q;
  assign busy         = busy_q;
  assign tx_done      = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three configurations (8N1, 8E1, 8O2) share clock, reset and baud_clk.
// A frame-level model (list of line bits advanced per baud rising edge) is compared every cycle; literal frames pin it.
module tb_uart_tx_serializer;
  localparam int NDUT = 3;

  logic clock_in = 1'b0;
  logic rst;
  logic baud_clk;
  always #5 clock_in = ~clock_in;

  logic [NDUT-1:0] vld;
  logic [7:0]      dat [NDUT];
  wire  [NDUT-1:0] rdyv, txv, bsyv, dnv;

  uart_tx_serializer_if #(.DATA_BITS(8)) bus0 ();
  uart_tx_serializer_if #(.DATA_BITS(8)) bus1 ();
  uart_tx_serializer_if #(.DATA_BITS(8)) bus2 ();
  assign bus0.tx_valid = vld[0];
  assign bus0.tx_data  = dat[0];
  assign bus1.tx_valid = vld[1];
  assign bus1.tx_data  = dat[1];
  assign bus2.tx_valid = vld[2];
  assign bus2.tx_data  = dat[2];
  assign rdyv[0] = bus0.tx_ready;
  assign rdyv[1] = bus1.tx_ready;
  assign rdyv[2] = bus2.tx_ready;

  uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clock_in(clock_in), .rst(rst), .baud_clk(baud_clk), .bus(bus0),
    .tx(txv[0]), .busy(bsyv[0]), .tx_done(dnv[0]));
  uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
    .clock_in(clock_in), .rst(rst), .baud_clk(baud_clk), .bus(bus1),
    .tx(txv[1]), .busy(bsyv[1]), .tx_done(dnv[1]));
  uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
    .clock_in(clock_in), .rst(rst), .baud_clk(baud_clk), .bus(bus2),
    .tx(txv[2]), .busy(bsyv[2]), .tx_done(dnv[2]));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clock_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  int cfg_par  [NDUT] = '{0, 1, 1};
  int cfg_odd  [NDUT] = '{0, 0, 1};
  int cfg_stop [NDUT] = '{1, 1, 2};

  bit        m_tx [NDUT], m_rdy [NDUT], m_bsy [NDUT], m_dn [NDUT], m_act [NDUT];
  bit [15:0] m_bits [NDUT];
  int        m_len [NDUT], m_pos [NDUT];
  bit        m_prev, tick;

  always @(posedge clock_in or posedge rst) begin
    if (rst) begin
      m_prev = 1'b0;
      for (int i = 0; i < NDUT; i++) begin
        m_tx[i] = 1'b1; m_rdy[i] = 1'b1; m_bsy[i] = 1'b0; m_dn[i] = 1'b0; m_act[i] = 1'b0;
      end
    end else begin
      tick   = baud_clk && !m_prev;
      m_prev = baud_clk;
      for (int i = 0; i < NDUT; i++) begin
        m_dn[i] = 1'b0;
        if (!m_act[i]) begin
          if (vld[i] && m_rdy[i]) begin
            // line bits in order: start, data LSB first, optional parity, stop bits
            m_bits[i] = '0;
            m_len[i]  = 0;
            m_bits[i][m_len[i]++] = 1'b0;
            for (int b = 0; b < 8; b++) m_bits[i][m_len[i]++] = dat[i][b];
            if (cfg_par[i] != 0)
              m_bits[i][m_len[i]++] = 1'(($countones(dat[i]) % 2) ^ cfg_odd[i]);
            for (int s = 0; s < cfg_stop[i]; s++) m_bits[i][m_len[i]++] = 1'b1;
            m_act[i] = 1'b1; m_pos[i] = -1; m_rdy[i] = 1'b0; m_bsy[i] = 1'b1;
          end
        end else if (tick) begin
          m_pos[i]++;
          if (m_pos[i] == m_len[i]) begin
            m_act[i] = 1'b0; m_dn[i] = 1'b1; m_rdy[i] = 1'b1; m_bsy[i] = 1'b0; m_tx[i] = 1'b1;
          end else begin
            m_tx[i] = m_bits[i][m_pos[i]];
          end
        end
      end
    end
  end

  always @(posedge clock_in) begin
    #2;
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("tx[%0d]", i),       txv[i],  m_tx[i]);
      chk($sformatf("tx_ready[%0d]", i), rdyv[i], m_rdy[i]);
      chk($sformatf("busy[%0d]", i),     bsyv[i], m_bsy[i]);
      chk($sformatf("tx_done[%0d]", i),  dnv[i],  m_dn[i]);
    end
  end

  // ---------------- baud clock source ----------------
  int half_lo = 4, half_hi = 4;
  bit stall_req = 1'b0;
  initial begin
    int h;
    baud_clk = 1'b0;
    forever begin
      h = $urandom_range(half_hi, half_lo);
      repeat (h) @(negedge clock_in);
      if (stall_req) begin
        repeat (60) @(negedge clock_in);
        stall_req = 1'b0;
      end
      baud_clk = ~baud_clk;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int i, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clock_in);
    vld[i] = 1'b1;
    dat[i] = d;
    while (!rdyv[i] && n < 2000) begin
      @(negedge clock_in);
      n++;
    end
    checks++;
    if (!rdyv[i]) begin
      errors++;
      $display("FAIL accept[%0d]: tx_ready still 0 after %0d cycles, expected 1", i, n);
    end
    @(negedge clock_in);
    vld[i] = 1'b0;
  endtask

  // Samples each bit mid-period (bits are 8 cycles here) and times tx_done from the start-bit edge.
  task automatic trace(input int i, input int nbits, input logic [15:0] want,
                       input int want_done, input string name, output int t0);
    logic [15:0] got, mask;
    logic        rdy_seen;
    int          n;
    got = '0; rdy_seen = 1'b0; n = 0;
    mask = (16'h1 << nbits) - 16'h1;
    while (txv[i] && n < 400) begin
      @(negedge clock_in);
      n++;
    end
    t0 = cyc;
    repeat (4) @(negedge clock_in);
    for (int k = 0; k < nbits; k++) begin
      got[k]   = txv[i];
      rdy_seen = rdy_seen | rdyv[i];
      if (k < nbits - 1) repeat (8) @(negedge clock_in);
    end
    checks++;
    if ((got & mask) !== want) begin
      errors++;
      $display("FAIL %s frame: got %b, expected %b", name, got & mask, want);
    end
    checks++;
    if (rdy_seen !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_in_frame: got %b, expected 0", name, rdy_seen);
    end
    n = 0;
    while (!dnv[i] && n < 100) begin
      @(negedge clock_in);
      n++;
    end
    checks++;
    if (!dnv[i] || (cyc - t0) != want_done) begin
      errors++;
      $display("FAIL %s done_time: got %0d cycles (done=%b), expected %0d", name, cyc - t0, dnv[i], want_done);
    end
  endtask

  task automatic rnd_drive(input int i, input int nfr);
    int gap, noise;
    for (int f = 0; f < nfr; f++) begin
      gap = $urandom_range(0, 20);
      repeat (gap) @(negedge clock_in);
      send(i, 8'($urandom));
      noise = $urandom_range(5, 40);
      for (int c = 0; c < noise; c++) begin
        @(negedge clock_in);
        dat[i] = 8'($urandom);
        if (c == 3) vld[i] = 1'b1;
        if (c == 5) vld[i] = 1'b0;
      end
      vld[i] = 1'b0;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t0a, t0b, n;
    rst = 1'b1;
    vld = '0;
    for (int i = 0; i < NDUT; i++) dat[i] = 8'h00;
    @(posedge clock_in);
    #2;
    chk("reset tx", txv[0], 1'b1);
    chk("reset tx_ready", rdyv[0], 1'b1);
    chk("reset busy", bsyv[0], 1'b0);
    chk("reset tx_done", dnv[0], 1'b0);
    repeat (3) @(negedge clock_in);
    rst = 1'b0;
    repeat (10) @(negedge clock_in);

    // 0xA5 on 8N1
    send(0, 8'hA5);
    trace(0, 10, 16'b1101001010, 80, "a5_8n1", t0a);
    // 0xA5 with even parity (bit 0), then odd parity + 2 stops (bit 1)
    send(1, 8'hA5);
    trace(1, 11, 16'b10101001010, 88, "a5_even", t0a);
    send(2, 8'hA5);
    trace(2, 12, 16'b111101001010, 96, "a5_odd_2stop", t0a);
    // 0x0F with 2 stops: stop high for 16 cycles before tx_done
    send(2, 8'h0F);
    trace(2, 12, 16'b111000011110, 96, "0f_2stop", t0a);

    // back-to-back 0x00 then 0xFF with tx_valid held
    @(negedge clock_in);
    vld[0] = 1'b1;
    dat[0] = 8'h00;
    n = 0;
    while (!rdyv[0] && n < 100) begin
      @(negedge clock_in);
      n++;
    end
    @(negedge clock_in);
    dat[0] = 8'hFF;
    trace(0, 10, 16'b1000000000, 80, "b2b_00", t0a);
    chk("b2b ready_on_done", rdyv[0], 1'b1);
    @(negedge clock_in);
    vld[0] = 1'b0;
    trace(0, 10, 16'b1111111110, 80, "b2b_ff", t0b);
    checks++;
    if ((t0b - t0a - 72) != 16) begin
      errors++;
      $display("FAIL b2b gap: got %0d high cycles, expected 16", t0b - t0a - 72);
    end
    repeat (20) @(negedge clock_in);

    // stray valid mid-frame is ignored
    send(0, 8'h55);
    fork
      trace(0, 10, 16'b1010101010, 80, "ignore_55", t0a);
      begin
        repeat (30) @(negedge clock_in);
        vld[0] = 1'b1;
        dat[0] = 8'h3C;
        @(negedge clock_in);
        chk("ignore ready_mid_frame", rdyv[0], 1'b0);
        repeat (2) @(negedge clock_in);
        vld[0] = 1'b0;
      end
    join
    repeat (100) @(negedge clock_in);
    chk("ignore idle_tx", txv[0], 1'b1);
    chk("ignore idle_busy", bsyv[0], 1'b0);

    // reset during data bit 3 (bit 3 of 0x50 is 0)
    send(0, 8'h50);
    n = 0;
    while (txv[0] && n < 400) begin
      @(negedge clock_in);
      n++;
    end
    repeat (36) @(negedge clock_in);
    chk("midrst tx_before", txv[0], 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst tx_async", txv[0], 1'b1);
    chk("midrst ready_async", rdyv[0], 1'b1);
    chk("midrst done", dnv[0], 1'b0);
    repeat (3) @(negedge clock_in);
    rst = 1'b0;
    repeat (5) @(negedge clock_in);
    send(0, 8'h81);
    trace(0, 10, 16'b1100000010, 80, "post_rst_81", t0a);
    repeat (20) @(negedge clock_in);

    // randomized phase: irregular baud periods, a stalled divider, noisy producers
    half_lo = 1;
    half_hi = 6;
    fork
      rnd_drive(0, 15);
      rnd_drive(1, 15);
      rnd_drive(2, 15);
      begin
        repeat (300) @(negedge clock_in);
        stall_req = 1'b1;
      end
    join
    repeat (400) @(negedge clock_in);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
